// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC frame assembler.
//   state_t     - one-hot FSM state encoding (IDLE, LOCK, RUN, LOST)
//   FCO_PATTERN - frame clock word expected on every aligned frame
package adc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOCK = 4'b0010,
    ST_RUN  = 4'b0100,
    ST_LOST = 4'b1000
  } state_t;

  localparam logic [7:0] FCO_PATTERN = 8'hF0;

endpackage

// File: rtl/adc_ramp_checker.sv
// adc_ramp_checker: checks that successive valid samples form a +1 ramp.
// The first valid word while run=1 seeds the expectation; a mismatch counts
// an error and reseeds from the received word. Dropping run unseeds.
// Ports:
//   CLKDIV, rst   - clock, async active-high reset
//   run           - FSM is in RUN
//   word_valid    - word is being captured as a valid sample this cycle
//   word          - interleaved sample word
//   err_clr       - synchronous clear, wins over increment
//   err_cnt       - saturating ramp error counter
module adc_ramp_checker #(
  parameter int ERR_W = 16
) (
  input  logic             CLKDIV,
  input  logic             rst,
  input  logic             run,
  input  logic             word_valid,
  input  logic [15:0]      word,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
);

  logic        seeded;
  logic [15:0] expect_word;
  logic        mismatch;

  assign mismatch = run && word_valid && seeded && (word != expect_word);

  always_ff @(posedge CLKDIV or posedge rst) begin
    if (rst) begin
      seeded      <= 1'b0;
      expect_word <= 16'h0000;
    end else if (!run) begin
      seeded <= 1'b0;
    end else if (word_valid) begin
      // seeding, matching and reseeding all expect word+1 next
      seeded      <= 1'b1;
      expect_word <= word + 16'd1;
    end
  end

  always_ff @(posedge CLKDIV or posedge rst) begin
    if (rst)                       err_cnt <= '0;
    else if (err_clr)              err_cnt <= '0;
    else if (mismatch && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: rtl/adc_frame_assembler.sv
// adc_frame_assembler: locks onto the deserialized ADC frame clock word,
// interleaves the two data lanes into 16-bit samples and counts errors.
// Optional feature macro: ADC_RAMP_CHECK_EN (instantiates adc_ramp_checker;
// without it ramp_err_cnt is tied to zero).
// Ports:
//   CLKDIV                    - frame-rate clock
//   rst                       - async active-high reset
//   aligned                   - bitslip stage reports alignment done
//   ISERDES_FCO               - frame clock word
//   ISERDES_D0/D1             - data lanes 0/1
//   err_clr                   - sync clear of both error counters
//   sample/sample_valid       - assembled sample, registered, 1-cycle latency
//   locked                    - state is RUN
//   realign_req               - state is LOST
//   frame_err_cnt/ramp_err_cnt- saturating error counters
module adc_frame_assembler
  import adc_pkg::*;
#(
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 16
) (
  input  logic             CLKDIV,
  input  logic             rst,
  input  logic             aligned,
  input  logic [7:0]       ISERDES_FCO,
  input  logic [7:0]       ISERDES_D0,
  input  logic [7:0]       ISERDES_D1,
  input  logic             err_clr,
  output logic [15:0]      sample,
  output logic             sample_valid,
  output logic             locked,
  output logic             realign_req,
  output logic [ERR_W-1:0] frame_err_cnt,
  output logic [ERR_W-1:0] ramp_err_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic        fco_ok;
  logic        word_valid;
  logic        frame_err;
  logic [15:0] word;

  assign fco_ok      = (ISERDES_FCO == FCO_PATTERN);
  assign word_valid  = (state == ST_RUN) && fco_ok;
  assign frame_err   = (state == ST_RUN) && aligned && !fco_ok;
  assign locked      = (state == ST_RUN);
  assign realign_req = (state == ST_LOST);

  always_comb begin
    word = '0;
    for (int i = 0; i < 8; i++) begin
      word[2*i]   = ISERDES_D0[i];
      word[2*i+1] = ISERDES_D1[i];
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = 8'd0;
    case (state)
      ST_IDLE: if (aligned) state_nxt = ST_LOCK;
      ST_LOCK: begin
        if (!aligned) begin
          state_nxt = ST_IDLE;
        end else if (fco_ok) begin
          if (lock_cnt == 8'(LOCK_CYCLES - 1)) state_nxt = ST_RUN;
          else                                 lock_cnt_nxt = lock_cnt + 8'd1;
        end
      end
      ST_RUN: begin
        if (!aligned)    state_nxt = ST_IDLE;
        else if (!fco_ok) state_nxt = ST_LOST;
      end
      ST_LOST: if (!aligned) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKDIV or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge CLKDIV or posedge rst) begin
    if (rst) begin
      sample       <= 16'h0000;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= word_valid;
      if (word_valid) sample <= word;
    end
  end

  always_ff @(posedge CLKDIV or posedge rst) begin
    if (rst)                                 frame_err_cnt <= '0;
    else if (err_clr)                        frame_err_cnt <= '0;
    else if (frame_err && !(&frame_err_cnt)) frame_err_cnt <= frame_err_cnt + 1'b1;
  end

`ifdef ADC_RAMP_CHECK_EN
  adc_ramp_checker #(.ERR_W(ERR_W)) u_ramp (
    .CLKDIV     (CLKDIV),
    .rst        (rst),
    .run        (state == ST_RUN),
    .word_valid (word_valid),
    .word       (word),
    .err_clr    (err_clr),
    .err_cnt    (ramp_err_cnt)
  );
`else
  assign ramp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_frame_assembler.sv
// Self-checking bench for adc_frame_assembler (ERR_W=2 so saturation is
// reachable). A behavioural model tracks mode, lock progress, counters and
// the ramp expectation from the datasheet-level rules.
module tb_adc_frame_assembler;
  localparam int LOCK_CYCLES = 4;
  localparam int ERR_W       = 2;
  localparam int CMAX        = (1 << ERR_W) - 1;
  localparam int M_IDLE = 0, M_LOCK = 1, M_RUN = 2, M_LOST = 3;

  logic             CLKDIV = 1'b0;
  logic             rst = 1'b1;
  logic             aligned = 1'b0;
  logic [7:0]       ISERDES_FCO = 8'h00, ISERDES_D0 = 8'h00, ISERDES_D1 = 8'h00;
  logic             err_clr = 1'b0;
  logic [15:0]      sample;
  logic             sample_valid, locked, realign_req;
  logic [ERR_W-1:0] frame_err_cnt, ramp_err_cnt;

  adc_frame_assembler #(.LOCK_CYCLES(LOCK_CYCLES), .ERR_W(ERR_W)) dut (
    .CLKDIV(CLKDIV), .rst(rst), .aligned(aligned), .ISERDES_FCO(ISERDES_FCO),
    .ISERDES_D0(ISERDES_D0), .ISERDES_D1(ISERDES_D1), .err_clr(err_clr),
    .sample(sample), .sample_valid(sample_valid), .locked(locked),
    .realign_req(realign_req), .frame_err_cnt(frame_err_cnt),
    .ramp_err_cnt(ramp_err_cnt)
  );

  always #5 CLKDIV = ~CLKDIV;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_mode, m_matches, m_ferr, m_rerr, m_exp;
  bit m_seeded, m_valid;
  logic [15:0] m_sample;
`ifdef ADC_RAMP_CHECK_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  task automatic model_reset();
    m_mode = M_IDLE; m_matches = 0; m_ferr = 0; m_rerr = 0;
    m_exp = 0; m_seeded = 0; m_valid = 0; m_sample = 16'h0000;
  endtask

  // lane 0 bits land on even sample positions, lane 1 on odd ones
  function automatic logic [15:0] interleave(input logic [7:0] a, input logic [7:0] b);
    int s = 0;
    for (int i = 0; i < 8; i++) s = s + a[i] * (4 ** i) + b[i] * 2 * (4 ** i);
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, int'(locked), int'(m_mode == M_RUN));
    chk({tag, ".realign"}, int'(realign_req), int'(m_mode == M_LOST));
    chk({tag, ".valid"}, int'(sample_valid), int'(m_valid));
    chk({tag, ".sample"}, int'(sample), int'(m_sample));
    chk({tag, ".ferr"}, int'(frame_err_cnt), m_ferr);
    chk({tag, ".rerr"}, int'(ramp_err_cnt), RAMP_ON ? m_rerr : 0);
  endtask

  // one frame: apply inputs, advance model, clock, then compare off-edge
  task automatic frame(input bit al, input logic [7:0] fco, input logic [15:0] w,
                       input bit clr, input string tag);
    bit good = (fco == 8'hF0);
    aligned = al; ISERDES_FCO = fco; err_clr = clr;
    for (int i = 0; i < 8; i++) begin
      ISERDES_D0[i] = w[2*i];
      ISERDES_D1[i] = w[2*i+1];
    end
    m_valid = (m_mode == M_RUN) && good;
    if (m_valid) m_sample = w;
    if (m_mode == M_RUN && good) begin
      if (m_seeded && int'(w) != m_exp && !clr && m_rerr < CMAX) m_rerr++;
      m_seeded = 1; m_exp = (int'(w) + 1) % 65536;
    end else if (m_mode != M_RUN) m_seeded = 0;
    if (clr) m_rerr = 0;
    if (clr) m_ferr = 0;
    else if (m_mode == M_RUN && al && !good && m_ferr < CMAX) m_ferr++;
    case (m_mode)
      M_IDLE: begin m_matches = 0; if (al) m_mode = M_LOCK; end
      M_LOCK: if (!al) begin m_mode = M_IDLE; m_matches = 0; end
              else if (!good) m_matches = 0;
              else if (m_matches + 1 == LOCK_CYCLES) begin m_mode = M_RUN; m_matches = 0; end
              else m_matches++;
      M_RUN:  if (!al) m_mode = M_IDLE; else if (!good) m_mode = M_LOST;
      default: if (!al) m_mode = M_IDLE;
    endcase
    @(posedge CLKDIV); #1;
    check_all(tag);
  endtask

  task automatic relock();
    int n = 0;
    frame(1'b0, 8'hF0, 16'h0, 1'b0, "idle");
    while (!locked && n < 20) begin
      frame(1'b1, 8'hF0, 16'(n), 1'b0, "lock");
      n++;
    end
    // one edge leaves IDLE, then LOCK_CYCLES matches
    chk("lock_edges", n, LOCK_CYCLES + 1);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge CLKDIV); rst = 1'b0;

    // lock sequence: locked after the 4th LOCK edge, valid one cycle later
    relock();
    frame(1'b1, 8'hF0, interleave(8'hFF, 8'h00), 1'b0, "il_5555");
    chk("il_5555_val", int'(sample), 16'h5555);
    frame(1'b1, 8'hF0, interleave(8'h00, 8'hFF), 1'b0, "il_aaaa");
    chk("il_aaaa_val", int'(sample), 16'hAAAA);

    // frame loss then aligned drop
    frame(1'b1, 8'hE1, 16'h1111, 1'b0, "loss");
    chk("loss_ferr", int'(frame_err_cnt), 1);
    frame(1'b1, 8'hF0, 16'h2222, 1'b0, "lost_hold");
    frame(1'b0, 8'hF0, 16'h3333, 1'b0, "to_idle");

    // saturation: three more losses reach 3, a fourth stays 3
    for (int k = 0; k < 4; k++) begin
      relock();
      frame(1'b1, 8'hE1, 16'h0, 1'b0, "sat_loss");
    end
    chk("sat_ferr", int'(frame_err_cnt), 3);
    relock();
    frame(1'b1, 8'hE1, 16'h0, 1'b1, "clr_loss");
    chk("clr_ferr", int'(frame_err_cnt), 0);

    // ramp 0..0x10 with 0x0008 corrupted
    relock();
    for (int v = 0; v <= 16; v++)
      frame(1'b1, 8'hF0, (v == 8) ? 16'h1234 : 16'(v), 1'b0, "ramp");
    chk("ramp_err", int'(ramp_err_cnt), RAMP_ON ? 2 : 0);
    frame(1'b1, 8'hF0, 16'h0011, 1'b1, "ramp_clr");

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit al = ($urandom_range(0, 31) != 0);
      logic [7:0] fco = ($urandom_range(0, 15) != 0) ? 8'hF0 : 8'($urandom);
      logic [15:0] w = ($urandom_range(0, 3) != 0) ? 16'(m_exp) : 16'($urandom);
      frame(al, fco, w, ($urandom_range(0, 63) == 0), "rand");
    end

    // asynchronous reset mid-RUN, between edges
    relock();
    frame(1'b1, 8'hF0, 16'hBEEF, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    #2 rst = 1'b0;
    relock();
    frame(1'b1, 8'hF0, 16'h4321, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adc_frame_assembler.md
ADC_FRAME_ASSEMBLER -- requirements
Module: adc_frame_assembler

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 4, consecutive 8'hF0 frame words required to lock (range 1..255).
REQ-002 SHALL have parameter ERR_W, default 16, width of each error counter.
REQ-003 SHALL have port CLKDIV  in  1  divided (frame-rate) clock; sole clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port aligned  in  1  frame-alignment-done flag from bitslip stage, sticky until its reset.
REQ-006 SHALL have port ISERDES_FCO  in  8  deserialized frame clock word.
REQ-007 SHALL have ports ISERDES_D0, ISERDES_D1  in  8 each  deserialized data lanes 0 and 1 (two-lane, 16-bit mode).
REQ-008 SHALL have port err_clr  in  1  synchronous clear of both error counters.
REQ-009 SHALL have port sample  out  16  assembled ADC sample.
REQ-010 SHALL have port sample_valid  out  1  sample qualifier.
REQ-011 SHALL have port locked  out  1  high while state is RUN.
REQ-012 SHALL have port realign_req  out  1  request to restart the bitslip stage.
REQ-013 SHALL have ports frame_err_cnt, ramp_err_cnt  out  ERR_W each  saturating error counters.

Function
REQ-014 SHALL implement one-hot FSM IDLE, LOCK, RUN, LOST.
REQ-015 IDLE: lock counter held 0; aligned=1 -> LOCK.
REQ-016 LOCK: aligned=0 -> IDLE; FCO==8'hF0 increments lock counter, mismatch zeroes it; the LOCK_CYCLES-th consecutive match -> RUN on that edge.
REQ-017 RUN: aligned=0 -> IDLE (priority); FCO!=8'hF0 -> LOST and frame_err_cnt+1.
REQ-018 LOST: realign_req=1 (combinational from state); aligned=0 -> IDLE.
REQ-019 Interleave: sample[2i]=ISERDES_D0[i], sample[2i+1]=ISERDES_D1[i], i=0..7.
REQ-020 sample and sample_valid registered; latency exactly 1 CLKDIV cycle from input word to output.
REQ-021 sample_valid=1 only for words captured in RUN with FCO==8'hF0; the mismatching word yields sample_valid=0.
REQ-022 sample holds its last value when sample_valid=0.
REQ-023 Counters saturate at all-ones, never wrap.
REQ-024 err_clr and increment in same cycle: clear wins, counter reads 0.
REQ-025 locked=1 exactly in RUN; realign_req=1 exactly in LOST.

Reset
REQ-026 rst=1 asynchronously forces state IDLE, lock counter 0, sample 16'h0000, sample_valid 0, both counters 0.
REQ-027 Reset mid-RUN drops sample_valid and locked immediately, without waiting for a clock edge.

Configuration
REQ-028 With ADC_RAMP_CHECK_EN defined: ramp checker enabled; first valid sample after entering RUN seeds expected value; each following valid sample compared against previous+1 mod 2^16; mismatch increments ramp_err_cnt and reseeds from received sample.
REQ-029 Leaving RUN SHALL unseed the checker.
REQ-030 Without ADC_RAMP_CHECK_EN: ramp_err_cnt tied to 0, no checker logic synthesized; port list unchanged.

Structure
REQ-031 Package adc_pkg SHALL hold state enum type and constant FCO_PATTERN=8'hF0.
REQ-032 Ramp checker SHALL be sub-module adc_ramp_checker, instantiated only under ADC_RAMP_CHECK_EN.

Verification
REQ-033 Lock: aligned=1, FCO=8'hF0 held, LOCK_CYCLES=4 -> locked=1 after 4th edge; first sample_valid one cycle later.
REQ-034 Interleave: D0=8'hFF, D1=8'h00 -> sample=16'h5555; D0=8'h00, D1=8'hFF -> 16'hAAAA.
REQ-035 Frame loss: in RUN, one word FCO=8'hE1 -> that word sample_valid=0, frame_err_cnt=1, realign_req=1; aligned dropped -> IDLE, realign_req=0.
REQ-036 Saturation/clear: ERR_W=2, four frame losses -> frame_err_cnt=3; err_clr coincident with fifth loss -> 0.
REQ-037 Ramp (macro on): ramp 0x0000..0x0010 with 0x0008 replaced by 0x1234 -> ramp_err_cnt=2; macro off -> 0.
REQ-038 Async reset: rst pulsed between edges in RUN -> sample_valid, locked, sample, counters 0 immediately; relock requires LOCK_CYCLES matches.
